// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 clock,
// samples data on filtered falling edges and checks start/odd-parity/stop framing.
module ps2_frame_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_valid,
  output logic       ps2_err,
  output logic       ps2_busy
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;
  logic          evt_q, evt_bit_q;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  // Filtered clock follows the synchronized clock only after FILT_LEN differing cycles.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILT_LEN - 1)) filt_d = clk_sync_q[1];
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      evt_q       <= 1'b0;
      evt_bit_q   <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2k_clk};
      data_sync_q <= {data_sync_q[0], ps2k_data};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      evt_q       <= fall;
      if (fall) evt_bit_q <= data_sync_q[1];
    end
  end

  // tmo_q holds cycles elapsed since the last sample event; the abort fires as it reaches TIMEOUT_CYC.
  assign tmo_hit = (state_q != IDLE) && !evt_q && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_50M) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (evt_q) begin
      case (state_q)
        IDLE:    if (!evt_bit_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = '0;
    if (state_d != IDLE) tmo_d = evt_q ? TW'(1) : tmo_q + 1'b1;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (evt_q) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
          parity_d  = 1'b0;
        end
        DATA: begin
          shift_d   = {evt_bit_q, shift_q[7:1]};
          parity_d  = parity_q ^ evt_bit_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: parity_d = parity_q ^ evt_bit_q;
        STOP: begin
          if (evt_bit_q && parity_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign ps2_byte  = byte_q;
  assign ps2_valid = valid_q;
  assign ps2_err   = err_q;
  assign ps2_busy  = (state_q != IDLE);

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: number of consecutive CLK_50M cycles a synchronized ps2k_clk level must hold before the filtered clock follows it.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: idle cycles allowed mid-frame before abort (1 ms at 50 MHz).
REQ-003 SHALL have port CLK_50M, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ps2k_clk, input, 1: asynchronous PS/2 device clock.
REQ-006 SHALL have port ps2k_data, input, 1: asynchronous PS/2 device data.
REQ-007 SHALL have port ps2_byte, output, 8: last correctly received data byte.
REQ-008 SHALL have port ps2_valid, output, 1: one-cycle pulse when ps2_byte is updated.
REQ-009 SHALL have port ps2_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.
REQ-010 SHALL have port ps2_busy, output, 1: high while a frame is in progress (FSM not IDLE).

Function
REQ-011 SHALL pass ps2k_clk and ps2k_data each through a 2-flop synchronizer preset to 1.
REQ-012 SHALL update the filtered clock only after the synchronized clock differs from it for FILT_LEN consecutive cycles; shorter pulses SHALL be ignored.
REQ-013 SHALL generate a registered one-cycle sample event on each 1->0 transition of the filtered clock, capturing the synchronized data in the same cycle.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: event with data 0 -> DATA with bit count 0 and parity accumulator 0; event with data 1 -> stay in IDLE, no error.
REQ-016 DATA: each event shifts data into the shift register LSB first and XORs it into the parity accumulator; after the 8th bit -> PARITY.
REQ-017 PARITY: event XORs the parity bit into the accumulator -> STOP.
REQ-018 STOP: event with data 1 and accumulator 1 (odd parity) -> load ps2_byte and pulse ps2_valid; otherwise pulse ps2_err with ps2_byte unchanged; in both cases -> IDLE.
REQ-019 ps2_valid/ps2_err SHALL assert in the cycle immediately after the cycle carrying the STOP-state sample event, for exactly one cycle, and SHALL never assert together.
REQ-020 Outside IDLE, a cycle counter SHALL clear on every sample event and increment otherwise; on reaching TIMEOUT_CYC it SHALL pulse ps2_err and return to IDLE in the same transition.
REQ-021 In IDLE the timeout counter SHALL hold at 0; a counter sized ceil(log2(TIMEOUT_CYC+1)) bits SHALL never wrap.
REQ-022 ps2_byte SHALL hold its value between valid pulses; back-to-back frames SHALL be accepted with no dead cycles beyond filter latency.

Reset
REQ-023 On RST: state IDLE, ps2_byte=0x00, ps2_valid=0, ps2_err=0, ps2_busy=0, counters 0, synchronizer and filtered clock at 1.
REQ-024 RST asserted mid-frame SHALL abort the frame silently (no ps2_err) and SHALL take priority over any simultaneous sample event.

Verification
REQ-025 Frame 0x1C, parity 0, stop 1, 40 us bit period -> one ps2_valid pulse, ps2_byte=0x1C, ps2_err never high, ps2_busy low afterward.
REQ-026 Frame 0x1C with parity 1 -> one ps2_err pulse, ps2_byte keeps its prior value, no ps2_valid.
REQ-027 Frame 0x75 with stop bit 0 -> one ps2_err pulse; a following good 0xF0 frame (parity 1) -> ps2_valid, ps2_byte=0xF0.
REQ-028 Start + 5 data bits then bus held high -> ps2_err exactly TIMEOUT_CYC cycles after the last sample event, ps2_busy drops in the same cycle.
REQ-029 3-cycle low glitch on ps2k_clk while idle -> no sample event, ps2_busy stays 0; 12-cycle low pulse with data 0 -> ps2_busy rises.
REQ-030 RST pulsed after 4 data bits of a frame -> no ps2_valid/ps2_err; subsequent good 0xE0 frame (parity 0) -> ps2_valid, ps2_byte=0xE0.
